advanced_packet_fifo: RTL and testbench
=======================================

Name: advanced_packet_fifo

Overview:
Synchronous packet-mode FIFO with speculative writes. Packets become visible to the reader only when their last beat is written, and a partial packet can be discarded. It adds packet framing, commit/rollback, overflow-drop and packet counting to the advanced FIFO's status, level and threshold features. It sits between packet producers (MAC, DMA, decoders) and consumers that must never see truncated packets.

Parameters:
WIDTH, 8, data beat width in bits (≥1)
DEPTH, 8, storage depth in beats; power of two, ≥2
DEPTH_LOG2, `CLOG2(DEPTH), derived; do not override

Ports:
clock  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all contents and state
write_enable  input  1  write one beat
write_data  input  WIDTH  beat data
write_last  input  1  beat is the last of its packet; commits the packet
write_drop  input  1  discard the uncommitted partial packet
read_enable  input  1  consume the head beat
read_data  output  WIDTH  head beat, first-word fall-through
read_last  output  1  head beat is the last of its packet
empty  output  1  no committed beat available
not_empty  output  1  inverse of empty
full  output  1  no free slot, committed plus pending
not_full  output  1  inverse of full
write_miss  output  1  one-cycle pulse: write rejected by overflow
read_error  output  1  one-cycle pulse: read while empty
packet_dropped  output  1  one-cycle pulse: a packet was discarded
level  output  DEPTH_LOG2+1  committed beats stored
pending_level  output  DEPTH_LOG2+1  uncommitted beats stored
packet_count  output  DEPTH_LOG2+1  complete packets stored

Behaviour:
- Storage: WIDTH+1 bits per entry (data + last flag), internal register array, no reset on the array.
- Three pointers, each DEPTH_LOG2+1 bits with a wrap bit: write_pointer (speculative), commit_pointer, read_pointer. All wrap modulo 2·DEPTH.
- level = commit_pointer − read_pointer. pending_level = write_pointer − commit_pointer. full = (write_pointer − read_pointer == DEPTH). empty = (level == 0).
- Reset (resetn low, asynchronous) and flush (synchronous, highest priority): all pointers 0, packet_count 0, state IDLE, all pulses 0.
  - Resulting outputs: empty=1, not_empty=0, full=0, not_full=1, level=0, pending_level=0.
- Write state machine:
  - IDLE/ACCEPT: write_enable && !full stores the beat at write_pointer and increments it.
    - If write_last is also set: commit_pointer is set to the new write_pointer and packet_count increments.
  - Overflow: write_enable && full.
    - write_miss pulses.
    - write_pointer rewinds to commit_pointer.
    - If that beat has write_last: packet_dropped pulses, stay in ACCEPT.
    - Otherwise: go to DROPPING.
  - DROPPING: every write is ignored and does not pulse write_miss. A write with write_last pulses packet_dropped and returns to ACCEPT.
- write_drop (any state): write_pointer rewinds to commit_pointer, state goes to ACCEPT, and packet_dropped pulses if pending_level ≠ 0 or state was DROPPING.
  - A beat presented in the same cycle is discarded.
  - write_drop has priority over write_enable.
- Full is evaluated on pre-cycle state. A write while full is a miss even if a read happens in the same cycle.
- Read side:
  - read_data/read_last are driven combinationally from read_pointer, zero latency. They are valid only when not_empty.
  - read_enable && !empty increments read_pointer. If read_last, packet_count decrements.
  - read_enable && empty: read_error pulses and nothing changes.
- Same-cycle commit and read: packet_count increments and decrements net to 0. The read is based on pre-cycle empty.
- Status flags, level and counts are registered-pointer derived and update in the cycle after the event.

Optional Feature:
- Macro: ADVANCED_PACKET_FIFO_THRESHOLDS_EN.
- When defined, the block adds:
  - inputs lower_threshold_level and upper_threshold_level, each DEPTH_LOG2+1 bits;
  - outputs lower_threshold_status = (level ≤ lower_threshold_level) and upper_threshold_status = (level + pending_level ≥ upper_threshold_level);
  - outputs almost_empty (level==1) and almost_full (free slots==1).
- When undefined, these ports and their logic are absent.

Test Plan:
- Reset, then write 3 beats 0x11,0x22,0x33 (last on 0x33) → empty=1 until the cycle after the 0x33 write, then level=3, packet_count=1, read_data=0x11.
- Write 2 beats, then write_drop → pending_level 2→0, packet_dropped pulse, empty stays 1, next packet 0xA0(last) reads back 0xA0 with read_last=1.
- DEPTH=8: write a 10-beat packet → full after 8 beats, write_miss on beat 9, beat 10 (last) pulses packet_dropped, level=0, pending_level=0.
- Read on empty FIFO → read_error pulse for 1 cycle, read_pointer unchanged, level=0.
- Two committed 1-beat packets, then read 1 beat while committing a 3rd in the same cycle → packet_count stays 2, level stays 2.
- Mid-packet flush with 4 pending beats and 2 committed → next cycle level=0, pending_level=0, packet_count=0, empty=1, state ACCEPT.

Source files
------------

// File: rtl/advanced_packet_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : advanced_packet_fifo_if
// Description : Bundles the write, read and status signals of
//               advanced_packet_fifo.
//               - master modport: producer/consumer side.
//               - slave modport : the FIFO itself.
//               Optional threshold signals exist only when
//               ADVANCED_PACKET_FIFO_THRESHOLDS_EN is defined.
// Ports       : flush, write_enable/data/last/drop, read_enable (to FIFO);
//               read_data/last, empty/not_empty, full/not_full, write_miss,
//               read_error, packet_dropped, level, pending_level,
//               packet_count (from FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
interface advanced_packet_fifo_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int DEPTH_LOG2 = $clog2(DEPTH)
);
  logic                  flush;
  logic                  write_enable;
  logic [WIDTH-1:0]      write_data;
  logic                  write_last;
  logic                  write_drop;
  logic                  read_enable;
  logic [WIDTH-1:0]      read_data;
  logic                  read_last;
  logic                  empty;
  logic                  not_empty;
  logic                  full;
  logic                  not_full;
  logic                  write_miss;
  logic                  read_error;
  logic                  packet_dropped;
  logic [DEPTH_LOG2:0]   level;
  logic [DEPTH_LOG2:0]   pending_level;
  logic [DEPTH_LOG2:0]   packet_count;
`ifdef ADVANCED_PACKET_FIFO_THRESHOLDS_EN
  logic [DEPTH_LOG2:0]   lower_threshold_level;
  logic [DEPTH_LOG2:0]   upper_threshold_level;
  logic                  lower_threshold_status;
  logic                  upper_threshold_status;
  logic                  almost_empty;
  logic                  almost_full;
`endif

  modport master (
`ifdef ADVANCED_PACKET_FIFO_THRESHOLDS_EN
    output lower_threshold_level, upper_threshold_level,
    input  lower_threshold_status, upper_threshold_status,
    input  almost_empty, almost_full,
`endif
    output flush, write_enable, write_data, write_last, write_drop,
    output read_enable,
    input  read_data, read_last, empty, not_empty, full, not_full,
    input  write_miss, read_error, packet_dropped,
    input  level, pending_level, packet_count
  );

  modport slave (
`ifdef ADVANCED_PACKET_FIFO_THRESHOLDS_EN
    input  lower_threshold_level, upper_threshold_level,
    output lower_threshold_status, upper_threshold_status,
    output almost_empty, almost_full,
`endif
    input  flush, write_enable, write_data, write_last, write_drop,
    input  read_enable,
    output read_data, read_last, empty, not_empty, full, not_full,
    output write_miss, read_error, packet_dropped,
    output level, pending_level, packet_count
  );
endinterface : advanced_packet_fifo_if
`default_nettype wire

// File: rtl/advanced_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : advanced_packet_fifo
// Description : Packet-mode FIFO with speculative writes.
//               - Beats are written at a speculative write pointer.
//               - A packet becomes visible to the reader only when its last
//                 beat commits it.
//               - A partial packet can be discarded with write_drop, or is
//                 discarded automatically on overflow.
//               Optional feature macro: ADVANCED_PACKET_FIFO_THRESHOLDS_EN
//               (adds threshold compare and almost_empty/almost_full outputs).
// Ports       : clock        - rising-edge clock
//               resetn       - asynchronous active-low reset
//               bus (slave)  - write side, read side and status signals
//                              (see advanced_packet_fifo_if)
// Revision    : 1.0 - initial release
// ============================================================================
module advanced_packet_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int DEPTH_LOG2 = $clog2(DEPTH)
) (
  input  wire                   clock,
  input  wire                   resetn,
  advanced_packet_fifo_if.slave bus
);

  localparam int                 c_AW        = DEPTH_LOG2;
  localparam logic [c_AW:0]      c_DEPTH_PTR = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0]      c_ONE       = (c_AW+1)'(1);

  typedef enum logic [0:0] {
    ST_ACCEPT   = 1'b0,
    ST_DROPPING = 1'b1
  } state_t;

  // Entry layout: {last, data}
  logic [WIDTH:0]  r_mem [DEPTH];

  state_t          r_state;
  state_t          w_state_next;

  logic [c_AW:0]   r_wp;   // speculative write pointer
  logic [c_AW:0]   r_cp;   // commit pointer (end of last complete packet)
  logic [c_AW:0]   r_rp;   // read pointer
  logic [c_AW:0]   r_packet_count;
  logic            r_write_miss;
  logic            r_read_error;
  logic            r_packet_dropped;

  logic [c_AW:0]   w_wp_next;
  logic [c_AW:0]   w_cp_next;
  logic            w_store;
  logic            w_commit;
  logic            w_miss_next;
  logic            w_dropped_next;

  logic [c_AW:0]   w_level;
  logic [c_AW:0]   w_pending;
  logic [c_AW:0]   w_used;
  logic            w_full;
  logic            w_empty;
  logic [WIDTH:0]  w_head;
  logic            w_read_ok;
  logic            w_read_error_next;
  logic            w_pop_last;

  // --------------------------------------------------------------------------
  // Pointer-derived status. The wrap bit makes full and empty distinguishable.
  // --------------------------------------------------------------------------
  assign w_level   = r_cp - r_rp;
  assign w_pending = r_wp - r_cp;
  assign w_used    = r_wp - r_rp;
  assign w_full    = (w_used == c_DEPTH_PTR);
  assign w_empty   = (w_level == '0);
  assign w_head    = r_mem[r_rp[c_AW-1:0]];

  // --------------------------------------------------------------------------
  // Write-side state machine: next state and pointer updates
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_wp_next      = r_wp;
    w_cp_next      = r_cp;
    w_store        = 1'b0;
    w_commit       = 1'b0;
    w_miss_next    = 1'b0;
    w_dropped_next = 1'b0;

    if (bus.write_drop) begin
      // Explicit discard wins over any beat presented in the same cycle.
      w_wp_next      = r_cp;
      w_state_next   = ST_ACCEPT;
      w_dropped_next = (w_pending != '0) || (r_state == ST_DROPPING);
    end else if (bus.write_enable) begin
      case (r_state)
        ST_ACCEPT: begin
          if (!w_full) begin
            w_store   = 1'b1;
            w_wp_next = r_wp + c_ONE;
            if (bus.write_last) begin
              w_cp_next = r_wp + c_ONE;
              w_commit  = 1'b1;
            end
          end else begin
            // Overflow: abandon the partial packet. If this beat was not
            // the last one, swallow the remainder of the packet silently.
            w_miss_next = 1'b1;
            w_wp_next   = r_cp;
            if (bus.write_last) begin
              w_dropped_next = 1'b1;
            end else begin
              w_state_next = ST_DROPPING;
            end
          end
        end
        ST_DROPPING: begin
          if (bus.write_last) begin
            w_dropped_next = 1'b1;
            w_state_next   = ST_ACCEPT;
          end
        end
        default: begin
          w_state_next = ST_ACCEPT;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read side: decisions use pre-cycle empty, so a beat committed this cycle
  // is not readable until the next one.
  // --------------------------------------------------------------------------
  always_comb begin
    w_read_ok         = bus.read_enable && !w_empty;
    w_read_error_next = bus.read_enable && w_empty;
    w_pop_last        = w_read_ok && w_head[WIDTH];
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_ACCEPT;
    end else if (bus.flush) begin
      r_state <= ST_ACCEPT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, packet counter and event pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wp             <= '0;
      r_cp             <= '0;
      r_rp             <= '0;
      r_packet_count   <= '0;
      r_write_miss     <= 1'b0;
      r_read_error     <= 1'b0;
      r_packet_dropped <= 1'b0;
    end else if (bus.flush) begin
      r_wp             <= '0;
      r_cp             <= '0;
      r_rp             <= '0;
      r_packet_count   <= '0;
      r_write_miss     <= 1'b0;
      r_read_error     <= 1'b0;
      r_packet_dropped <= 1'b0;
    end else begin
      r_wp             <= w_wp_next;
      r_cp             <= w_cp_next;
      r_write_miss     <= w_miss_next;
      r_read_error     <= w_read_error_next;
      r_packet_dropped <= w_dropped_next;
      if (w_read_ok) begin
        r_rp <= r_rp + c_ONE;
      end
      // Simultaneous commit and last-beat read cancel out.
      if (w_commit && !w_pop_last) begin
        r_packet_count <= r_packet_count + c_ONE;
      end else if (!w_commit && w_pop_last) begin
        r_packet_count <= r_packet_count - c_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage array (not reset; contents are qualified by the pointers)
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_store && !bus.flush) begin
      r_mem[r_wp[c_AW-1:0]] <= {bus.write_last, bus.write_data};
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.read_data      = w_head[WIDTH-1:0];
  assign bus.read_last      = w_head[WIDTH];
  assign bus.empty          = w_empty;
  assign bus.not_empty      = !w_empty;
  assign bus.full           = w_full;
  assign bus.not_full       = !w_full;
  assign bus.write_miss     = r_write_miss;
  assign bus.read_error     = r_read_error;
  assign bus.packet_dropped = r_packet_dropped;
  assign bus.level          = w_level;
  assign bus.pending_level  = w_pending;
  assign bus.packet_count   = r_packet_count;

`ifdef ADVANCED_PACKET_FIFO_THRESHOLDS_EN
  // The upper threshold counts pending beats too, so a producer can be
  // throttled before a large packet overflows.
  assign bus.lower_threshold_status = (w_level <= bus.lower_threshold_level);
  assign bus.upper_threshold_status =
    ((w_level + w_pending) >= bus.upper_threshold_level);
  assign bus.almost_empty           = (w_level == c_ONE);
  assign bus.almost_full            = ((c_DEPTH_PTR - w_used) == c_ONE);
`endif

endmodule : advanced_packet_fifo
`default_nettype wire

// File: tb/tb_advanced_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_advanced_packet_fifo
// Description : Self-checking bench for advanced_packet_fifo (WIDTH=8,
//               DEPTH=8).
//               - A table of per-cycle stimulus records with expected status
//                 values is applied in order.
//               - A queue scoreboard holds committed beats and checks
//                 read_data/read_last on every accepted read.
//               - A short hand-written sequence covers asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_advanced_packet_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  advanced_packet_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  advanced_packet_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock  (clk),
    .resetn (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    bit         we;
    logic [7:0] data;
    bit         last;
    bit         drop;
    bit         re;
    bit         fl;
    int         lvl;
    int         pend;
    int         pc;
    bit         emp;
    bit         ful;
    bit         miss;
    bit         rerr;
    bit         dropd;
  } vec_t;

  vec_t        vec_q[$];
  logic [8:0]  pend_q[$];   // {last, data} of uncommitted beats
  logic [8:0]  comm_q[$];   // {last, data} of committed beats
  bit          m_dropping;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit we, input logic [7:0] data, input bit last,
                     input bit drop, input bit re, input bit fl,
                     input int lvl, input int pend, input int pc,
                     input bit emp, input bit ful, input bit miss,
                     input bit rerr, input bit dropd);
    vec_t v;
    v.we = we; v.data = data; v.last = last; v.drop = drop; v.re = re; v.fl = fl;
    v.lvl = lvl; v.pend = pend; v.pc = pc; v.emp = emp; v.ful = ful;
    v.miss = miss; v.rerr = rerr; v.dropd = dropd;
    vec_q.push_back(v);
  endtask

  task automatic drive_idle();
    bus.flush        = 1'b0;
    bus.write_enable = 1'b0;
    bus.write_data   = '0;
    bus.write_last   = 1'b0;
    bus.write_drop   = 1'b0;
    bus.read_enable  = 1'b0;
  endtask

  // Scoreboard update for one cycle, using pre-cycle model state.
  task automatic model_cycle(input vec_t v, input string tag);
    bit m_full;
    logic [8:0] head;
    m_full = ((comm_q.size() + pend_q.size()) == DEPTH);
    if (v.fl) begin
      pend_q.delete();
      comm_q.delete();
      m_dropping = 1'b0;
    end else begin
      if (v.re && comm_q.size() > 0) begin
        head = comm_q.pop_front();
        chk({tag, " read_data"}, 32'(bus.read_data), 32'(head[7:0]));
        chk({tag, " read_last"}, 32'(bus.read_last), 32'(head[8]));
      end
      if (v.drop) begin
        pend_q.delete();
        m_dropping = 1'b0;
      end else if (v.we) begin
        if (m_dropping) begin
          if (v.last) m_dropping = 1'b0;
        end else if (!m_full) begin
          pend_q.push_back({v.last, v.data});
          if (v.last) begin
            foreach (pend_q[k]) comm_q.push_back(pend_q[k]);
            pend_q.delete();
          end
        end else begin
          pend_q.delete();
          if (!v.last) m_dropping = 1'b1;
        end
      end
    end
  endtask

  initial begin
    drive_idle();
`ifdef ADVANCED_PACKET_FIFO_THRESHOLDS_EN
    bus.lower_threshold_level = '0;
    bus.upper_threshold_level = '0;
`endif
    m_dropping = 1'b0;

    // ---------------- stimulus table ----------------
    //   we data   last drop re fl   lvl pend pc emp ful miss rerr dropd
    // 3-beat packet: invisible until the last beat commits it
    add(1, 8'h11, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0, 0);
    add(1, 8'h22, 0, 0, 0, 0,   0, 2, 0, 1, 0, 0, 0, 0);
    add(1, 8'h33, 1, 0, 0, 0,   3, 0, 1, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0,   2, 0, 1, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0,   1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0,   0, 0, 0, 1, 0, 0, 0, 0);
    // partial packet discarded, then a 1-beat packet
    add(1, 8'h44, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0, 0);
    add(1, 8'h55, 0, 0, 0, 0,   0, 2, 0, 1, 0, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0,   0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 8'hA0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0,   0, 0, 0, 1, 0, 0, 0, 0);
    // read while empty
    add(0, 8'h00, 0, 0, 1, 0,   0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0);
    // 10-beat packet into 8 slots: full, miss on beat 9, drop on beat 10
    for (int i = 1; i <= 8; i++)
      add(1, 8'(8'hB0 + i), 0, 0, 0, 0,   0, i, 0, 1, (i == 8), 0, 0, 0);
    add(1, 8'hB9, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1, 0, 0);
    add(1, 8'hBA, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 1);
    // commit and read in the same cycle
    add(1, 8'hC1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 8'hC2, 1, 0, 0, 0,   2, 0, 2, 0, 0, 0, 0, 0);
    add(1, 8'hC3, 1, 0, 1, 0,   2, 0, 2, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0,   1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0,   0, 0, 0, 1, 0, 0, 0, 0);
    // flush with 2 committed packets and 4 pending beats
    add(1, 8'hD1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 8'hD2, 1, 0, 0, 0,   2, 0, 2, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      add(1, 8'(8'hE0 + i), 0, 0, 0, 0,   2, i, 2, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 8'hF0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0,   0, 0, 0, 1, 0, 0, 0, 0);
    // fill completely with one 8-beat packet
    for (int i = 1; i <= 8; i++)
      add(1, 8'(8'h60 + i), (i == 8), 0, 0, 0,
          (i == 8) ? 8 : 0, (i == 8) ? 0 : i, (i == 8) ? 1 : 0,
          (i != 8), (i == 8), 0, 0, 0);
    // write while full with a same-cycle read is still a miss
    add(1, 8'h70, 0, 0, 1, 0,   7, 0, 1, 0, 0, 1, 0, 0);
    // write_drop while DROPPING reports a dropped packet
    add(0, 8'h00, 0, 1, 0, 0,   7, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 6; i >= 0; i--)
      add(0, 8'h00, 0, 0, 1, 0,   i, 0, (i == 0) ? 0 : 1, (i == 0), 0, 0, 0, 0);

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("reset empty",     32'(bus.empty),         32'd1);
    chk("reset not_empty", 32'(bus.not_empty),     32'd0);
    chk("reset full",      32'(bus.full),          32'd0);
    chk("reset not_full",  32'(bus.not_full),      32'd1);
    chk("reset level",     32'(bus.level),         32'd0);
    chk("reset pending",   32'(bus.pending_level), 32'd0);
    chk("reset pcount",    32'(bus.packet_count),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- table ----------------
    for (int i = 0; i < vec_q.size(); i++) begin
      string tag;
      vec_t  v;
      v   = vec_q[i];
      tag = $sformatf("row%0d", i);
      bus.write_enable = v.we;
      bus.write_data   = v.data;
      bus.write_last   = v.last;
      bus.write_drop   = v.drop;
      bus.read_enable  = v.re;
      bus.flush        = v.fl;
      model_cycle(v, tag);
      @(posedge clk);
      #1;
      chk({tag, " level"},     32'(bus.level),          32'(v.lvl));
      chk({tag, " pending"},   32'(bus.pending_level),  32'(v.pend));
      chk({tag, " pcount"},    32'(bus.packet_count),   32'(v.pc));
      chk({tag, " empty"},     32'(bus.empty),          32'(v.emp));
      chk({tag, " not_empty"}, 32'(bus.not_empty),      32'(!v.emp));
      chk({tag, " full"},      32'(bus.full),           32'(v.ful));
      chk({tag, " not_full"},  32'(bus.not_full),       32'(!v.ful));
      chk({tag, " miss"},      32'(bus.write_miss),     32'(v.miss));
      chk({tag, " rerr"},      32'(bus.read_error),     32'(v.rerr));
      chk({tag, " dropped"},   32'(bus.packet_dropped), 32'(v.dropd));
      chk({tag, " sb level"},  32'(bus.level),          32'(comm_q.size()));
      chk({tag, " sb pend"},   32'(bus.pending_level),  32'(pend_q.size()));
    end
    drive_idle();

    // ---------------- asynchronous reset mid-cycle ----------------
    bus.write_enable = 1'b1;
    bus.write_data   = 8'h5A;
    bus.write_last   = 1'b1;
    @(posedge clk);
    #1;
    drive_idle();
    chk("pre-areset level", 32'(bus.level), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("areset level", 32'(bus.level), 32'd0);
    chk("areset empty", 32'(bus.empty), 32'd1);
    chk("areset pcount", 32'(bus.packet_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-areset not_full", 32'(bus.not_full), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_advanced_packet_fifo
`default_nettype wire
